// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types: register-address width default, x0
// and the scoreboard stage-entry record {valid, load, rd}.
package riscv_pipe_pkg;

  localparam int AW_DEFAULT = 5;
  localparam int X0 = 0;

  typedef struct packed {
    logic                  valid;
    logic                  load;
    logic [AW_DEFAULT-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/scoreboard_stage.sv
// One scoreboard entry register with reset, clear and load-enable.
// Ports: clk, rst (sync, active-low), clr, en, d -> q.
module scoreboard_stage
  import riscv_pipe_pkg::*;
#(
  parameter type entry_t = sb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   en,
  input  entry_t d,
  output entry_t q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard: tracks in-flight destinations,
// flags source hazards, load-use stalls and the write-back tap.
// Ports: issue_*, rs1/rs2(+_used), stall, squash in;
// stage_valid/stage_rd, hz_*, load_use, wb_*, in_flight out.
module hazard_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int DEPTH        = 3,
  parameter int AW           = AW_DEFAULT,
  parameter int SQUASH_DEPTH = 1,
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_wr,
  input  logic              issue_load,
  input  logic [AW-1:0]     issue_rd,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic              stall,
  input  logic              squash,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [DEPTH*AW-1:0] stage_rd,
  output logic              hz_rs1,
  output logic              hz_rs2,
  output logic [SW-1:0]     hz_rs1_stage,
  output logic [SW-1:0]     hz_rs2_stage,
  output logic              load_use,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_rd,
  output logic [CW-1:0]     in_flight
);

  typedef struct packed {
    logic          valid;
    logic          load;
    logic [AW-1:0] rd;
  } entry_t;

  localparam logic [AW-1:0] RZ = AW'(X0);

  entry_t q [DEPTH];
  entry_t d [DEPTH];
  entry_t head;
  logic   nv;

  assign nv = issue_valid & issue_wr &
              (issue_rd != RZ) & ~squash;

  always_comb begin
    head = '0;
    if (nv) begin
      head.valid = 1'b1;
      head.load  = issue_load;
      head.rd    = issue_rd;
    end
  end

  // Squashed stages clear even under stall; the first
  // surviving stage takes a bubble only when the pipe moves.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic clr;
    assign clr = squash &
                 ((k < SQUASH_DEPTH) |
                  ((k == SQUASH_DEPTH) & ~stall));
    if (k == 0) begin : g_head
      assign d[k] = head;
    end else begin : g_shift
      assign d[k] = q[k-1];
    end
    scoreboard_stage #(.entry_t(entry_t)) u_stage (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (~stall),
      .d   (d[k]),
      .q   (q[k])
    );
    assign stage_valid[k]       = q[k].valid;
    assign stage_rd[k*AW +: AW] = q[k].rd;
  end

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    hz_rs1       = 1'b0;
    hz_rs1_stage = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rs1_used && rs1 != RZ &&
          q[k].valid && q[k].rd == rs1) begin
        hz_rs1       = 1'b1;
        hz_rs1_stage = SW'(k);
      end
    end
  end

  always_comb begin
    hz_rs2       = 1'b0;
    hz_rs2_stage = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rs2_used && rs2 != RZ &&
          q[k].valid && q[k].rd == rs2) begin
        hz_rs2       = 1'b1;
        hz_rs2_stage = SW'(k);
      end
    end
  end

  assign load_use = ((hz_rs1 & (hz_rs1_stage == '0)) |
                     (hz_rs2 & (hz_rs2_stage == '0))) &
                    q[0].load;

  assign wb_valid = q[DEPTH-1].valid;
  assign wb_rd    = q[DEPTH-1].rd;

  always_comb begin
    in_flight = '0;
    for (int k = 0; k < DEPTH; k++) begin
      in_flight = in_flight + CW'(q[k].valid);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard
// (DEPTH=3, AW=5, SQUASH_DEPTH=1).
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_wr, issue_load;
  logic [4:0]  issue_rd, rs1, rs2;
  logic        rs1_used, rs2_used, stall, squash;
  logic [2:0]  stage_valid;
  logic [14:0] stage_rd;
  logic        hz_rs1, hz_rs2;
  logic [1:0]  hz_rs1_stage, hz_rs2_stage;
  logic        load_use, wb_valid;
  logic [4:0]  wb_rd;
  logic [1:0]  in_flight;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .DEPTH(3), .AW(5), .SQUASH_DEPTH(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_wr     (issue_wr),
    .issue_load   (issue_load),
    .issue_rd     (issue_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_used     (rs1_used),
    .rs2_used     (rs2_used),
    .stall        (stall),
    .squash       (squash),
    .stage_valid  (stage_valid),
    .stage_rd     (stage_rd),
    .hz_rs1       (hz_rs1),
    .hz_rs2       (hz_rs2),
    .hz_rs1_stage (hz_rs1_stage),
    .hz_rs2_stage (hz_rs2_stage),
    .load_use     (load_use),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .in_flight    (in_flight)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [4:0] rd,
                       input logic ld);
    issue_valid = 1'b1;
    issue_wr    = 1'b1;
    issue_load  = ld;
    issue_rd    = rd;
  endtask

  task automatic no_issue();
    issue_valid = 1'b0;
    issue_wr    = 1'b0;
    issue_load  = 1'b0;
    issue_rd    = 5'd0;
  endtask

  initial begin
    rst = 1'b0;
    no_issue();
    rs1 = 0; rs2 = 0;
    rs1_used = 0; rs2_used = 0;
    stall = 0; squash = 0;
    tick(); tick();
    rst = 1'b1;
    settle();
    chk("rst_valid", 32'(stage_valid), 32'h0);
    chk("rst_inflight", 32'(in_flight), 32'h0);
    chk("rst_wb", 32'(wb_valid), 32'h0);
    chk("rst_ld_use", 32'(load_use), 32'h0);

    // rd=5 travels down the pipe and retires
    issue(5'd5, 1'b0);
    tick();
    no_issue();
    rs1 = 5'd5; rs1_used = 1'b1;
    settle();
    chk("t1_valid", 32'(stage_valid), 32'h1);
    chk("t1_hz", 32'(hz_rs1), 32'h1);
    chk("t1_hzst", 32'(hz_rs1_stage), 32'h0);
    chk("t1_wb0", 32'(wb_valid), 32'h0);
    tick();
    chk("t1_valid2", 32'(stage_valid), 32'h2);
    chk("t1_hzst2", 32'(hz_rs1_stage), 32'h1);
    tick();
    chk("t1_valid3", 32'(stage_valid), 32'h4);
    chk("t1_wb", 32'(wb_valid), 32'h1);
    chk("t1_wbrd", 32'(wb_rd), 32'h5);
    chk("t1_hzst3", 32'(hz_rs1_stage), 32'h2);
    tick();
    chk("t1_gone", 32'(hz_rs1), 32'h0);
    chk("t1_wboff", 32'(wb_valid), 32'h0);
    chk("t1_empty", 32'(in_flight), 32'h0);

    // x0 is never tracked nor matched
    issue(5'd0, 1'b0);
    tick();
    no_issue();
    rs1 = 5'd0;
    settle();
    chk("x0_valid", 32'(stage_valid), 32'h0);
    chk("x0_inflight", 32'(in_flight), 32'h0);
    chk("x0_hz", 32'(hz_rs1), 32'h0);
    rs1_used = 1'b0;

    // load-use, held under stall with issue ignored
    issue(5'd7, 1'b1);
    tick();
    no_issue();
    rs2 = 5'd7; rs2_used = 1'b1;
    settle();
    chk("lu_flag", 32'(load_use), 32'h1);
    chk("lu_hzst", 32'(hz_rs2_stage), 32'h0);
    stall = 1'b1;
    issue(5'd11, 1'b0);
    tick();
    chk("lu_hold_v", 32'(stage_valid), 32'h1);
    chk("lu_hold_rd", 32'(stage_rd), 32'h7);
    chk("lu_hold_f", 32'(load_use), 32'h1);
    stall = 1'b0;
    no_issue();
    tick();
    chk("lu_rel_v", 32'(stage_valid), 32'h2);
    chk("lu_rel_f", 32'(load_use), 32'h0);
    chk("lu_rel_hz", 32'(hz_rs2), 32'h1);
    chk("lu_rel_st", 32'(hz_rs2_stage), 32'h1);
    rs2_used = 1'b0;
    tick(); tick();
    chk("lu_empty", 32'(in_flight), 32'h0);

    // squash: stage 0 killed, stage 1 bubble, stage 2 shifts
    issue(5'd3, 1'b0); tick();
    issue(5'd4, 1'b0); tick();
    issue(5'd6, 1'b0); tick();
    chk("sq_full", 32'(stage_valid), 32'h7);
    chk("sq_inflt3", 32'(in_flight), 32'h3);
    chk("sq_rd", 32'(stage_rd), 32'h0C86);
    issue(5'd9, 1'b0);
    squash = 1'b1;
    tick();
    squash = 1'b0;
    no_issue();
    rs1 = 5'd9; rs1_used = 1'b1;
    rs2 = 5'd6; rs2_used = 1'b1;
    settle();
    chk("sq_valid", 32'(stage_valid), 32'h4);
    chk("sq_inflt", 32'(in_flight), 32'h1);
    chk("sq_wbrd", 32'(wb_rd), 32'h4);
    chk("sq_no9", 32'(hz_rs1), 32'h0);
    chk("sq_no6", 32'(hz_rs2), 32'h0);
    rs1_used = 1'b0; rs2_used = 1'b0;
    tick();
    chk("sq_empty", 32'(in_flight), 32'h0);

    // squash under stall: stage 0 cleared, rest hold
    issue(5'd12, 1'b0); tick();
    issue(5'd13, 1'b0); tick();
    no_issue();
    stall = 1'b1; squash = 1'b1;
    tick();
    stall = 1'b0; squash = 1'b0;
    settle();
    chk("sqst_valid", 32'(stage_valid), 32'h2);
    chk("sqst_rd", 32'(stage_rd), 32'h0180);
    tick(); tick();
    chk("sqst_empty", 32'(in_flight), 32'h0);

    // youngest match wins
    issue(5'd8, 1'b0); tick();
    issue(5'd2, 1'b0); tick();
    issue(5'd8, 1'b0); tick();
    no_issue();
    rs1 = 5'd8; rs1_used = 1'b1;
    rs2 = 5'd2; rs2_used = 1'b1;
    settle();
    chk("yw_hz", 32'(hz_rs1), 32'h1);
    chk("yw_st", 32'(hz_rs1_stage), 32'h0);
    chk("yw_st2", 32'(hz_rs2_stage), 32'h1);
    chk("yw_nolu", 32'(load_use), 32'h0);

    // reset beats stall with a full pipe
    stall = 1'b1;
    rst = 1'b0;
    issue(5'd10, 1'b1);
    tick();
    rst = 1'b1;
    stall = 1'b0;
    no_issue();
    settle();
    chk("rr_valid", 32'(stage_valid), 32'h0);
    chk("rr_rd", 32'(stage_rd), 32'h0);
    chk("rr_inflt", 32'(in_flight), 32'h0);
    chk("rr_wb", 32'({wb_valid, wb_rd}), 32'h0);
    chk("rr_hz", 32'({hz_rs1, hz_rs2, load_use}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
